// File: rtl/dot_prod_host.sv
// Host-side initiator for the `main` dot-product datapath: loads arr_a/arr_b, kicks off a run, returns the result.
// Optional load readback checksum under `DOT_PROD_HOST_READBACK_EN` (adds CHECK state and chk_error).
`timescale 1ns/1ps
module dot_prod_host #(
  parameter int N       = 1000,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 27,
  parameter int RES_W   = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [RES_W-1:0]  out_result,
  output logic                     out_timeout,
  output logic                     busy,
`ifdef DOT_PROD_HOST_READBACK_EN
  output logic                     chk_error,
`endif
  output logic                     dut_r_enable,
  output logic                     dut_control_arr,
  output logic [RES_W-1:0]         dut_init_i,
  output logic [RES_W-1:0]         dut_init_acc,
  output logic                     dut_we_a,
  output logic                     dut_we_b,
  output logic [ADDR_W-1:0]        dut_addr,
  output logic [DATA_W-1:0]        dut_wdata_a,
  output logic [DATA_W-1:0]        dut_wdata_b,
  input  logic [DATA_W-1:0]        dut_rdata_a,
  input  logic [DATA_W-1:0]        dut_rdata_b,
  input  logic                     dut_w_enable,
  input  logic signed [RES_W-1:0]  dut_result
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_LOAD, S_CHECK, S_START, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [TW-1:0]     timer;
  logic              last, ld, hs, timer_end;

  assign last      = (cnt == ADDR_W'(N - 1));
  assign timer_end = (timer == TW'(TIMEOUT - 1));
  // LOAD outputs are masked while reset is held so everything reads 0 during reset.
  assign ld        = (state == S_LOAD) && !reset;
  assign hs        = in_valid && in_ready;

  assign dut_init_i   = '0;
  assign dut_init_acc = '0;
  assign dut_we_a     = ld && in_valid;
  assign dut_we_b     = ld && in_valid;
  assign dut_wdata_a  = ld ? in_a : '0;
  assign dut_wdata_b  = ld ? in_b : '0;
  assign dut_addr     = (ld || state == S_CHECK) ? cnt : '0;
  assign out_valid    = (state == S_DONE);
  assign busy         = !(state == S_LOAD && cnt == '0);

  always_comb begin
    state_nxt       = state;
    in_ready        = 1'b0;
    dut_control_arr = 1'b0;
    dut_r_enable    = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready        = ld;
        dut_control_arr = ld;
        if (hs && last) begin
`ifdef DOT_PROD_HOST_READBACK_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_START;
`endif
        end
      end
      S_CHECK: begin
        dut_control_arr = 1'b1;
        if (last) state_nxt = S_START;
      end
      S_START: begin
        dut_r_enable = 1'b1;
        state_nxt    = S_RUN;
      end
      // w_enable seen during START is left over from the previous run; only RUN looks at it.
      S_RUN: begin
        if (dut_w_enable || timer_end) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LOAD;
      cnt         <= '0;
      timer       <= '0;
      out_result  <= '0;
      out_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_LOAD:  if (hs) cnt <= last ? '0 : cnt + ADDR_W'(1);
        S_CHECK: cnt <= last ? '0 : cnt + ADDR_W'(1);
        S_START: timer <= '0;
        S_RUN: begin
          if (dut_w_enable) begin
            out_result  <= dut_result;
            out_timeout <= 1'b0;
          end else if (timer_end) begin
            out_result  <= '0;
            out_timeout <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DOT_PROD_HOST_READBACK_EN
  logic [2*DATA_W-1:0] chk_wr, chk_rd, rd_nxt;

  assign rd_nxt = (cnt == '0 ? '0 : chk_rd) ^ {dut_rdata_a, dut_rdata_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_wr    <= '0;
      chk_rd    <= '0;
      chk_error <= 1'b0;
    end else begin
      if (state == S_LOAD && hs) begin
        // First handshake of a batch restarts the checksum and clears the sticky flag.
        chk_wr <= (cnt == '0 ? '0 : chk_wr) ^ {in_a, in_b};
        if (cnt == '0) chk_error <= 1'b0;
      end
      if (state == S_CHECK) begin
        chk_rd <= rd_nxt;
        if (last && rd_nxt != chk_wr) chk_error <= 1'b1;
      end
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^{dut_rdata_a, dut_rdata_b};
`endif

endmodule

// File: tb/tb_dot_prod_host.sv
// Directed bench for dot_prod_host with a stub `main` and a sum-of-products reference model.
`timescale 1ns/1ps
module tb_dot_prod_host;
  localparam int N = 4, AW = 2, DW = 27, RW = 64, TO = 16;

  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, out_timeout, busy;
  logic signed [DW-1:0] in_a = 0, in_b = 0;
  logic [RW-1:0] out_result, dut_init_i, dut_init_acc;
  logic dut_r_enable, dut_control_arr, dut_we_a, dut_we_b;
  logic [AW-1:0] dut_addr;
  logic [DW-1:0] dut_wdata_a, dut_wdata_b, dut_rdata_a, dut_rdata_b;
  logic dut_w_enable;
  logic signed [RW-1:0] dut_result;
`ifdef DOT_PROD_HOST_READBACK_EN
  logic chk_error;
`endif

  int checks = 0, failures = 0;
  bit no_resp = 0, corrupt = 0;
  int ta[4], tb_v[4];

  always #5 clk = ~clk;

  dot_prod_host #(.N(N), .ADDR_W(AW), .DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_timeout(out_timeout), .busy(busy),
`ifdef DOT_PROD_HOST_READBACK_EN
    .chk_error(chk_error),
`endif
    .dut_r_enable(dut_r_enable), .dut_control_arr(dut_control_arr),
    .dut_init_i(dut_init_i), .dut_init_acc(dut_init_acc),
    .dut_we_a(dut_we_a), .dut_we_b(dut_we_b), .dut_addr(dut_addr),
    .dut_wdata_a(dut_wdata_a), .dut_wdata_b(dut_wdata_b),
    .dut_rdata_a(dut_rdata_a), .dut_rdata_b(dut_rdata_b),
    .dut_w_enable(dut_w_enable), .dut_result(dut_result));

  // Stub main: arrays, combinational read, result 5 cycles after r_enable (or never).
  logic signed [DW-1:0] arr_a[N], arr_b[N];
  logic stub_w = 0;
  logic signed [RW-1:0] stub_res = 0;
  int lat = 0;
  assign dut_rdata_a  = arr_a[dut_addr];
  assign dut_rdata_b  = arr_b[dut_addr] ^ ((corrupt && dut_addr == 2) ? 27'd1 : 27'd0);
  assign dut_w_enable = stub_w;
  assign dut_result   = stub_res;

  function automatic logic signed [RW-1:0] stub_dot();
    logic signed [RW-1:0] s = 0, pa, pb;
    for (int i = 0; i < N; i++) begin
      pa = arr_a[i]; pb = arr_b[i]; s += pa * pb;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (dut_control_arr && dut_we_a) arr_a[dut_addr] <= dut_wdata_a;
    if (dut_control_arr && dut_we_b) arr_b[dut_addr] <= dut_wdata_b;
    if (dut_r_enable) begin
      lat <= 5; stub_w <= 0;
    end else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 1 && !no_resp) begin stub_w <= 1; stub_res <= stub_dot(); end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model + per-cycle compare.
  int idx = 0, cyc = 0, start_cyc = 0;
  logic signed [RW-1:0] acc = 0, ea, eb;
  logic [RW-1:0] exp_res[$];
  bit exp_to[$];
  bit armed = 0, prev_valid = 0, prev_ren = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      idx = 0; acc = 0; armed = 0; prev_valid = 0; prev_ren = 0;
      exp_res.delete(); exp_to.delete();
    end else begin
      if (in_valid && in_ready) begin
        chk("we_a_on_hs", {63'd0, dut_we_a}, 1);
        chk("we_b_on_hs", {63'd0, dut_we_b}, 1);
        chk("ctrl_on_hs", {63'd0, dut_control_arr}, 1);
        chk("addr", 64'(dut_addr), 64'(idx));
        chk("wdata_a", 64'(dut_wdata_a), 64'(in_a[DW-1:0]));
        chk("wdata_b", 64'(dut_wdata_b), 64'(in_b[DW-1:0]));
        ea = in_a; eb = in_b; acc += ea * eb; idx++;
        if (idx == N) begin
          exp_res.push_back(no_resp ? 64'd0 : acc);
          exp_to.push_back(no_resp);
          idx = 0; acc = 0; armed = 1;
        end
      end else begin
        chk("we_idle", {62'd0, dut_we_a, dut_we_b}, 0);
      end
      if (dut_r_enable) begin
        chk("r_enable_early", {63'd0, armed}, 1);
        chk("r_enable_width", {63'd0, prev_ren}, 0);
        chk("ctrl_in_start", {63'd0, dut_control_arr}, 0);
        armed = 0; start_cyc = cyc;
      end
      if (out_valid) begin
        if (exp_res.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          if (!prev_valid) chk("latency", 64'(cyc - start_cyc), exp_to[0] ? 64'(TO + 1) : 64'd7);
          chk("result", out_result, exp_res[0]);
          chk("timeout", {63'd0, out_timeout}, {63'd0, exp_to[0]});
          if (out_ready) begin void'(exp_res.pop_front()); void'(exp_to.pop_front()); end
        end
      end
      prev_valid = out_valid && !out_ready;
      prev_ren = dut_r_enable;
    end
  end

  task automatic send(input int a, input int b);
    int k;
    in_a = DW'(a); in_b = DW'(b); in_valid = 1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 200) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic batch(input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send(ta[i], tb_v[i]);
    end
  endtask

  task automatic wait_result(input string name, input logic [63:0] exp, input bit to);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) break;
    end
    if (k == 200) chk({name, "_wait"}, 0, 1);
    else begin
      chk(name, out_result, exp);
      chk({name, "_to"}, {63'd0, out_timeout}, {63'd0, to});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    in_valid = 1; in_a = 5; in_b = 7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 0);
    chk("rst_ctrl", {63'd0, dut_control_arr}, 0);
    chk("rst_we", {62'd0, dut_we_a, dut_we_b}, 0);
    chk("rst_wdata", {dut_wdata_a, dut_wdata_b}, 0);
    chk("rst_addr", 64'(dut_addr), 0);
    chk("rst_out", {61'd0, out_valid, out_timeout, dut_r_enable}, 0);
    chk("rst_result", out_result, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_init", dut_init_i | dut_init_acc, 0);
    @(posedge clk); #1;
    reset = 0; in_valid = 0; out_ready = 1;

    ta = '{1, 2, 3, 4}; tb_v = '{5, 6, 7, 8};
    send(ta[0], tb_v[0]);
    chk("busy_mid_load", {63'd0, busy}, 1);
    for (int i = 1; i < N; i++) send(ta[i], tb_v[i]);
    wait_result("basic", 64'd70, 0);

    ta = '{-3, 100, -67108864, 0}; tb_v = '{2, -1, 2, 9};
    batch(0);
    wait_result("signed", -64'sd134217834, 0);

    out_ready = 0;
    ta = '{7, -8, 9, 10}; tb_v = '{3, 4, -5, 6};
    batch(1);
    begin
      int k;
      for (k = 0; k < 200; k++) begin @(negedge clk); if (out_valid) break; end
      if (k == 200) chk("hold_wait", 0, 1);
    end
    repeat (20) begin @(negedge clk); chk("hold_valid", {63'd0, out_valid}, 1); end
    @(posedge clk); #1;
    out_ready = 1;
    wait_result("backpressure", 64'd4, 0);

    no_resp = 1;
    ta = '{1, 2, 3, 4}; tb_v = '{1, 2, 3, 4};
    batch(0);
    wait_result("timeout", 64'd0, 1);
    no_resp = 0;

    send(9, 9); send(9, 9);
    reset = 1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
    chk("busy_after_rst", {63'd0, busy}, 0);
    ta = '{1, 1, 1, 1}; tb_v = '{2, 2, 2, 2};
    batch(0);
    wait_result("after_reset", 64'd8, 0);

`ifdef DOT_PROD_HOST_READBACK_EN
    ta = '{1, 2, 3, 4}; tb_v = '{5, 6, 7, 8};
    for (int i = 0; i < N - 1; i++) send(ta[i], tb_v[i]);
    send(ta[N-1], tb_v[N-1]);
    corrupt = 1;
    wait_result("corrupt_run", 64'd70, 0);
    chk("chk_error_set", {63'd0, chk_error}, 1);
    corrupt = 0;
    send(ta[0], tb_v[0]);
    chk("chk_error_clr", {63'd0, chk_error}, 0);
    for (int i = 1; i < N; i++) send(ta[i], tb_v[i]);
    wait_result("clean_run", 64'd70, 0);
    chk("chk_error_clean", {63'd0, chk_error}, 0);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/dot_prod_host.md
Name: dot_prod_host

Overview:
- Host-side initiator for the generated `main` dot-product datapath. It drives the control-array ports and the `r_enable`/`w_enable` start/result protocol.
- Accepts a stream of (a,b) element pairs and loads them into `arr_a`/`arr_b` at addresses 0..N-1 through the control-array write ports.
- Then pulses `r_enable`, waits for `w_enable`, and returns the 64-bit result on a valid/ready output.
- Sits between the system stream fabric and one `main` instance.

Parameters:
- N, 1000, element count per vector; must match the array depth of `main`.
- ADDR_W, 10, control-array address width.
- DATA_W, 27, signed element width.
- RES_W, 64, result width.
- TIMEOUT, 4096, maximum cycles spent in RUN before the run is abandoned.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  element pair valid
- in_ready  out  1  element pair accepted when high together with in_valid
- in_a  in  DATA_W  signed element of vector a
- in_b  in  DATA_W  signed element of vector b
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_result  out  RES_W  signed dot product
- out_timeout  out  1  qualifies out_valid: run abandoned, out_result=0
- busy  out  1  high in every state except LOAD with cnt==0
- dut_r_enable  out  1  to main r_enable
- dut_control_arr  out  1  to main controlArr
- dut_init_i, dut_init_acc  out  RES_W each  to main init_i/init_acc; constant 0
- dut_we_a, dut_we_b  out  1  to controlArrWEnable_a/_b
- dut_addr  out  ADDR_W  to controlArrAddr_a and controlArrAddr_b
- dut_wdata_a, dut_wdata_b  out  DATA_W  to controlArrWData_a/_b
- dut_rdata_a, dut_rdata_b  in  DATA_W  from controlArrRData_a/_b; combinational read
- dut_w_enable  in  1  from main w_enable
- dut_result  in  RES_W  from main result

Behaviour:
- Reset. Enter LOAD with cnt=0 and timer=0. All outputs are 0 the cycle after reset asserts. Reset has priority in every state, including mid-LOAD and mid-RUN; partial loads are discarded.
- States: LOAD -> [CHECK] -> START -> RUN -> DONE -> LOAD.
- LOAD:
  - in_ready=1 and dut_control_arr=1; dut_addr=cnt.
  - dut_we_a=dut_we_b=in_valid. dut_wdata_a=in_a and dut_wdata_b=in_b, written the same cycle.
  - Each handshake increments cnt.
  - A handshake with cnt==N-1 goes to CHECK if compiled in, else START; cnt resets to 0.
  - No wrap: cnt never exceeds N-1.
- START (1 cycle): dut_control_arr=0, dut_r_enable=1, timer cleared.
- RUN:
  - dut_r_enable=0, dut_control_arr=0.
  - dut_w_enable is sampled only in RUN. Its value during START is stale from the previous run and is ignored.
  - dut_w_enable==1: latch dut_result into out_result, out_timeout=0, go to DONE.
  - Otherwise timer++. When timer==TIMEOUT-1 without w_enable: out_result=0, out_timeout=1, go to DONE.
  - Result latency is START + main's internal latency + 1 register stage.
- DONE:
  - out_valid=1; out_result and out_timeout are held stable until out_ready.
  - The handshake cycle returns to LOAD. in_ready stays 0 during DONE, so no overlap.
- dut_control_arr stays low outside LOAD/CHECK. dut_we_* is 0 in every state except LOAD.

Optional Feature:
- Macro: DOT_PROD_HOST_READBACK_EN.
- With it defined:
  - LOAD XOR-accumulates {in_a,in_b} into a 2*DATA_W checksum.
  - CHECK state lasts N cycles: dut_control_arr=1, we=0, dut_addr=cnt. Each cycle XORs {dut_rdata_a,dut_rdata_b} into a second accumulator.
  - At exit, a mismatch sets the sticky output chk_error (1 bit). chk_error clears on reset or at the first LOAD handshake of the next batch.
  - The run proceeds regardless of mismatch.
- Without it: no CHECK state, no chk_error port; LOAD goes directly to START.

Test Plan:
- N=4, a={1,2,3,4}, b={5,6,7,8}, out_ready=1 -> out_valid with out_result=70, out_timeout=0; dut_r_enable high for exactly 1 cycle.
- N=4, a={-3,100,-67108864,0}, b={2,-1,2,9} -> out_result=-134217834 (sign extension across 64 bits).
- Random in_valid gaps and out_ready held low 20 cycles -> writes only on handshakes, addresses 0..3 in order; out_result stable and out_valid high until out_ready.
- Stub main that never raises w_enable, TIMEOUT=16 -> out_valid with out_timeout=1 and out_result=0, 16 RUN cycles after START.
- Reset asserted after 2 of 4 loads, then 4 fresh pairs a={1,1,1,1}, b={2,2,2,2} -> out_result=8; no r_enable before the 4th load.
- With DOT_PROD_HOST_READBACK_EN: corrupt arr_b[2] through a backdoor during CHECK -> chk_error=1 while the result is still delivered; a clean next batch with its first handshake -> chk_error=0.
